zap_load_align_fifo: RTL and testbench
======================================

ZAP_LOAD_ALIGN_FIFO -- requirements
Module: zap_load_align_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WDT, default 32, meaning the load/store data width in bits; legal values are 32 and 64.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of buffer entries; legal values are powers of 2 from 2 to 16.
REQ-003 The block SHALL have parameter PHY_REGS, default 46, meaning the number of physical registers; IW = $clog2(PHY_REGS), AW = $clog2(DATA_WDT/8).
REQ-004 i_clk  in  1  single clock; all state is on the rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_clear_from_writeback  in  1  synchronous flush.
REQ-007 i_valid  in  1  input entry valid.
REQ-008 o_ready  out  1  buffer can accept an entry.
REQ-009 i_load  in  1  1 = load, 0 = store passthrough.
REQ-010 i_addr  in  AW  byte offset within the data word.
REQ-011 i_size  in  2  access size: 0 byte, 1 halfword, 2 word, 3 doubleword.
REQ-012 i_signed  in  1  sign-extend byte/halfword loads.
REQ-013 i_data  in  DATA_WDT  raw memory data (load) or store value.
REQ-014 i_fault  in  2  fault code from the cache; nonzero means faulted.
REQ-015 i_dest_index  in  IW  destination physical register.
REQ-016 o_valid  out  1  head entry valid.
REQ-017 i_ready  in  1  consumer accepts the head entry.
REQ-018 o_data  out  DATA_WDT  aligned/extended head data.
REQ-019 o_fault  out  2  head fault code.
REQ-020 o_dest_index  out  IW  head destination register.
REQ-021 o_misaligned  out  1  head access is unaligned for its size.
REQ-022 o_count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-023 The block SHALL accept a push when i_valid && o_ready, and retire a pop when o_valid && i_ready.
REQ-024 o_ready SHALL be (o_count < DEPTH); there is no full-bypass, so a push is refused when full even if a pop occurs in the same cycle.
REQ-025 An entry pushed into an empty buffer SHALL appear at o_valid in the next cycle; latency is 1 cycle and there is no combinational in-to-out path.
REQ-026 A simultaneous push and pop SHALL leave o_count unchanged and preserve FIFO order.
REQ-027 Read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-028 Each entry SHALL store the raw i_data and the input attributes; alignment SHALL be applied combinationally on the head entry.
REQ-029 For a store (load=0), o_data SHALL equal the stored data unmodified.
REQ-030 For a byte load, o_data SHALL be byte[addr], zero- or sign-extended according to signed.
REQ-031 For a halfword load, o_data SHALL be halfword[addr>>1], zero- or sign-extended according to signed.
REQ-032 For a word load with DATA_WDT=32, o_data SHALL be the data rotated right by 8*addr.
REQ-033 For a word load with DATA_WDT=64, o_data SHALL be word[addr[2]], zero-extended.
REQ-034 For a doubleword load with DATA_WDT=64, o_data SHALL be the data unmodified.
REQ-035 For a doubleword load with DATA_WDT=32, the access SHALL be treated as a word load.
REQ-036 o_misaligned SHALL be 1 for a load with (halfword && addr[0]), (word && addr[1:0]!=0), or (doubleword && DATA_WDT=64 && addr!=0); it is informational and does not alter data except via the word rotate.
REQ-037 When the head fault code is nonzero, o_data SHALL be forced to 0 and o_fault SHALL carry the code.
REQ-038 i_clear_from_writeback SHALL zero both pointers and o_count in the next cycle, and any push in that cycle SHALL be discarded.
REQ-039 When the buffer is empty, o_valid SHALL be 0 and o_data, o_fault, o_dest_index, and o_misaligned SHALL be 0.

Reset
REQ-040 Asserting i_reset SHALL immediately, without a clock, set both pointers to 0, o_count to 0, o_valid to 0, o_ready to 1, and o_data/o_fault/o_dest_index/o_misaligned to 0; entry storage need not be reset.
REQ-041 After reset deasserts, the first push SHALL be accepted on the first clock edge.
REQ-042 Reset asserted mid-transfer SHALL drop all entries, including one being pushed in that cycle.

Verification
REQ-043 DATA_WDT=32: push load, byte, signed=1, addr=2, data 0x12F45678 -> next cycle o_valid=1, o_data=0xFFFFFFF4.
REQ-044 DATA_WDT=32: word load, addr=1, data 0xAABBCCDD -> o_data=0xDDAABBCC, o_misaligned=1.
REQ-045 DATA_WDT=64: halfword load, signed=0, addr=6, data 0x8001_0000_0000_0000 -> o_data=0x0000_0000_0000_8001.
REQ-046 DEPTH=4, i_ready=0: push 5 entries -> o_ready=0 after the 4th, the 5th is not accepted, o_count=4; then push+pop together while full -> o_count=3.
REQ-047 Push 2 entries, assert i_clear_from_writeback with i_valid=1 -> next cycle o_count=0 and o_valid=0.
REQ-048 Push an entry with i_fault=2'b01, data 0xFFFFFFFF -> o_data=0, o_fault=01; async reset mid-stream -> o_valid=0 before the next edge.

Source files
------------

// File: rtl/zap_load_align_fifo_if.sv
// Handshake and bus bundle for the load-align FIFO: slave is the buffer, master the producer/consumer side.
interface zap_load_align_fifo_if #(
    parameter int DATA_WDT = 32,
    parameter int DEPTH    = 4,
    parameter int PHY_REGS = 46
);
    localparam int IW = $clog2(PHY_REGS);
    localparam int AW = $clog2(DATA_WDT / 8);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                i_valid;
    logic                o_ready;
    logic                i_load;
    logic [AW-1:0]       i_addr;
    logic [1:0]          i_size;
    logic                i_signed;
    logic [DATA_WDT-1:0] i_data;
    logic [1:0]          i_fault;
    logic [IW-1:0]       i_dest_index;
    logic                o_valid;
    logic                i_ready;
    logic [DATA_WDT-1:0] o_data;
    logic [1:0]          o_fault;
    logic [IW-1:0]       o_dest_index;
    logic                o_misaligned;
    logic [CW-1:0]       o_count;

    modport slave (
        input  i_valid, i_load, i_addr, i_size, i_signed, i_data, i_fault, i_dest_index, i_ready,
        output o_ready, o_valid, o_data, o_fault, o_dest_index, o_misaligned, o_count
    );

    modport master (
        output i_valid, i_load, i_addr, i_size, i_signed, i_data, i_fault, i_dest_index, i_ready,
        input  o_ready, o_valid, o_data, o_fault, o_dest_index, o_misaligned, o_count
    );
endinterface

// File: rtl/zap_load_align_fifo.sv
// Load-return buffer: stores raw memory data and attributes, aligns/extends the head entry on the way out.
module zap_load_align_fifo #(
    parameter int DATA_WDT = 32,
    parameter int DEPTH    = 4,
    parameter int PHY_REGS = 46
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_clear_from_writeback,
    zap_load_align_fifo_if.slave      bus
);
    localparam int IW = $clog2(PHY_REGS);
    localparam int AW = $clog2(DATA_WDT / 8);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic                load;
        logic [1:0]          size;
        logic                sgn;
        logic [AW-1:0]       addr;
        logic [DATA_WDT-1:0] data;
        logic [1:0]          fault;
        logic [IW-1:0]       dest;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop, not_empty;
    entry_t        head, in_entry;

    function automatic logic [DATA_WDT-1:0] align_data(input entry_t e);
        logic [2:0]          a;
        logic [1:0]          sz;
        logic [7:0]          b;
        logic [15:0]         h;
        logic [31:0]         w;
        logic [DATA_WDT-1:0] rot;
        logic [DATA_WDT-1:0] ret;
        int                  sh;
        a   = 3'(e.addr);
        sh  = 8 * int'(a);
        // A doubleword on a 32-bit bus degrades to a plain word access.
        sz  = (e.size == 2'd3 && DATA_WDT == 32) ? 2'd2 : e.size;
        b   = 8'(e.data >> sh);
        h   = 16'(e.data >> (16 * int'(a[2:1])));
        rot = (e.data >> sh) | (e.data << (DATA_WDT - sh));
        w   = (DATA_WDT == 64) ? 32'(e.data >> (32 * int'(a[2]))) : 32'(rot);
        ret = e.data;
        if (e.load) begin
            case (sz)
                2'd0: begin
                    ret      = {DATA_WDT{e.sgn & b[7]}};
                    ret[7:0] = b;
                end
                2'd1: begin
                    ret       = {DATA_WDT{e.sgn & h[15]}};
                    ret[15:0] = h;
                end
                2'd2: begin
                    ret       = '0;
                    ret[31:0] = w;
                end
                default: ret = e.data;
            endcase
        end
        return ret;
    endfunction

    function automatic logic is_misaligned(input entry_t e);
        logic [2:0] a;
        logic       mis;
        a = 3'(e.addr);
        case (e.size)
            2'd1:    mis = a[0];
            2'd2:    mis = (a[1:0] != 2'd0);
            2'd3:    mis = (DATA_WDT == 64) && (a != 3'd0);
            default: mis = 1'b0;
        endcase
        return e.load & mis;
    endfunction

    assign in_entry = '{load: bus.i_load, size: bus.i_size, sgn: bus.i_signed, addr: bus.i_addr,
                        data: bus.i_data, fault: bus.i_fault, dest: bus.i_dest_index};

    assign not_empty   = (count_q != '0);
    assign bus.o_ready = (count_q < CW'(DEPTH));
    assign push        = bus.i_valid && bus.o_ready && !i_clear_from_writeback;
    assign pop         = not_empty && bus.i_ready;
    assign bus.o_count = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_clear_from_writeback) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= in_entry;
    end

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        bus.o_valid      = 1'b0;
        bus.o_data       = '0;
        bus.o_fault      = 2'b00;
        bus.o_dest_index = '0;
        bus.o_misaligned = 1'b0;
        if (not_empty) begin
            bus.o_valid      = 1'b1;
            bus.o_fault      = head.fault;
            bus.o_dest_index = head.dest;
            bus.o_misaligned = is_misaligned(head);
            bus.o_data       = (head.fault != 2'b00) ? '0 : align_data(head);
        end
    end
endmodule

// File: tb/tb_zap_load_align_fifo.sv
// Randomized and directed bench for zap_load_align_fifo against a byte-level reference model.
module tb_zap_load_align_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr32 = 1'b0;
    logic clr64 = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    zap_load_align_fifo_if #(.DATA_WDT(32), .DEPTH(4), .PHY_REGS(46)) f32 ();
    zap_load_align_fifo_if #(.DATA_WDT(64), .DEPTH(4), .PHY_REGS(46)) f64 ();

    zap_load_align_fifo #(.DATA_WDT(32), .DEPTH(4), .PHY_REGS(46)) dut32 (
        .i_clk(clk), .i_reset(rst), .i_clear_from_writeback(clr32), .bus(f32));
    zap_load_align_fifo #(.DATA_WDT(64), .DEPTH(4), .PHY_REGS(46)) dut64 (
        .i_clk(clk), .i_reset(rst), .i_clear_from_writeback(clr64), .bus(f64));

    typedef struct {
        logic [63:0] data;
        logic [1:0]  flt;
        logic [5:0]  dest;
        logic        mis;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_data(input int W, input bit ld, input int sz, input bit sg,
                                             input int ad, input logic [63:0] d, input logic [1:0] flt);
        logic [7:0]  by[8];
        logic [63:0] r;
        int          base;
        for (int i = 0; i < 8; i++) by[i] = d[8*i +: 8];
        r = 64'h0;
        if (flt != 2'b00) return 64'h0;
        if (!ld) r = d;
        else begin
            if (sz == 3 && W == 32) sz = 2;
            case (sz)
                0: begin
                    r = {56'h0, by[ad]};
                    if (sg && by[ad][7]) r = r | ~64'hFF;
                end
                1: begin
                    r = {48'h0, by[(ad/2)*2+1], by[(ad/2)*2]};
                    if (sg && r[15]) r = r | ~64'hFFFF;
                end
                2: begin
                    if (W == 32) for (int i = 0; i < 4; i++) r[8*i +: 8] = by[(i + ad) % 4];
                    else begin
                        base = (ad >= 4) ? 4 : 0;
                        for (int i = 0; i < 4; i++) r[8*i +: 8] = by[base + i];
                    end
                end
                default: r = d;
            endcase
        end
        if (W == 32) r[63:32] = 32'h0;
        return r;
    endfunction

    function automatic logic ref_mis(input int W, input bit ld, input int sz, input int ad);
        return ld && ((sz == 1 && ad % 2 != 0) || (sz == 2 && ad % 4 != 0) || (sz == 3 && W == 64 && ad != 0));
    endfunction

    task automatic check32();
        exp_t h;
        h = '{64'h0, 2'b00, 6'h0, 1'b0};
        if (q32.size() != 0) h = q32[0];
        chk("v32",     f32.o_valid, q32.size() != 0);
        chk("cnt32",   f32.o_count, q32.size());
        chk("rdy32",   f32.o_ready, q32.size() < 4);
        chk("data32",  f32.o_data, h.data);
        chk("flt32",   f32.o_fault, h.flt);
        chk("dest32",  f32.o_dest_index, h.dest);
        chk("mis32",   f32.o_misaligned, h.mis);
    endtask

    task automatic check64();
        exp_t h;
        h = '{64'h0, 2'b00, 6'h0, 1'b0};
        if (q64.size() != 0) h = q64[0];
        chk("v64",    f64.o_valid, q64.size() != 0);
        chk("cnt64",  f64.o_count, q64.size());
        chk("data64", f64.o_data, h.data);
        chk("flt64",  f64.o_fault, h.flt);
        chk("mis64",  f64.o_misaligned, h.mis);
    endtask

    // Called on a falling edge; applies inputs across one rising edge and checks on the next falling edge.
    task automatic step32(input bit v, input bit rdy, input bit clr, input bit ld, input logic [1:0] sz,
                          input bit sg, input logic [1:0] ad, input logic [31:0] d,
                          input logic [1:0] f, input logic [5:0] dst);
        exp_t e;
        bit   push, pop;
        f32.i_valid = v; f32.i_ready = rdy; clr32 = clr; f32.i_load = ld; f32.i_size = sz;
        f32.i_signed = sg; f32.i_addr = ad; f32.i_data = d; f32.i_fault = f; f32.i_dest_index = dst;
        e.data = ref_data(32, ld, int'(sz), sg, int'(ad), {32'h0, d}, f);
        e.flt  = f;
        e.dest = dst;
        e.mis  = ref_mis(32, ld, int'(sz), int'(ad));
        push = v && q32.size() < 4 && !clr;
        pop  = q32.size() != 0 && rdy;
        if (clr) q32.delete();
        else begin
            if (pop)  void'(q32.pop_front());
            if (push) q32.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        check32();
    endtask

    task automatic step64(input bit v, input bit rdy, input bit ld, input logic [1:0] sz, input bit sg,
                          input logic [2:0] ad, input logic [63:0] d, input logic [1:0] f);
        exp_t e;
        bit   push, pop;
        f64.i_valid = v; f64.i_ready = rdy; f64.i_load = ld; f64.i_size = sz; f64.i_signed = sg;
        f64.i_addr = ad; f64.i_data = d; f64.i_fault = f; f64.i_dest_index = 6'd7;
        e.data = ref_data(64, ld, int'(sz), sg, int'(ad), d, f);
        e.flt  = f;
        e.dest = 6'd7;
        e.mis  = ref_mis(64, ld, int'(sz), int'(ad));
        push = v && q64.size() < 4;
        pop  = q64.size() != 0 && rdy;
        if (pop)  void'(q64.pop_front());
        if (push) q64.push_back(e);
        @(posedge clk);
        @(negedge clk);
        check64();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_v"},    f32.o_valid, 1'b0);
        chk({tag, "_cnt"},  f32.o_count, 3'd0);
        chk({tag, "_rdy"},  f32.o_ready, 1'b1);
        chk({tag, "_data"}, f32.o_data, 32'h0);
        chk({tag, "_flt"},  f32.o_fault, 2'b00);
        chk({tag, "_dst"},  f32.o_dest_index, 6'h0);
        chk({tag, "_mis"},  f32.o_misaligned, 1'b0);
    endtask

    initial begin
        f32.i_valid = 0; f32.i_ready = 0; f32.i_load = 0; f32.i_size = 0; f32.i_signed = 0;
        f32.i_addr = 0; f32.i_data = 0; f32.i_fault = 0; f32.i_dest_index = 0;
        f64.i_valid = 0; f64.i_ready = 0; f64.i_load = 0; f64.i_size = 0; f64.i_signed = 0;
        f64.i_addr = 0; f64.i_data = 0; f64.i_fault = 0; f64.i_dest_index = 0;

        #1 rst = 1'b1;
        #1 check_reset_outputs("rst0");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 64-bit datapath
        step64(1, 0, 1, 2'd1, 0, 3'd6, 64'h8001_0000_0000_0000, 2'b00);
        chk("r45_data", f64.o_data, 64'h0000_0000_0000_8001);
        step64(0, 1, 0, 2'd0, 0, 3'd0, 64'h0, 2'b00);
        for (int i = 0; i < 40; i++) begin
            step64(1, 0, $urandom_range(0, 3) != 0, 2'($urandom), 1'($urandom), 3'($urandom),
                   {$urandom, $urandom}, ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
            step64(0, 1, 0, 2'd0, 0, 3'd0, 64'h0, 2'b00);
        end
        f64.i_valid = 0;

        // First push right after reset is accepted; signed byte
        step32(1, 0, 0, 1, 2'd0, 1, 2'd2, 32'h12F45678, 2'b00, 6'd5);
        chk("r43_v", f32.o_valid, 1'b1);
        chk("r43_data", f32.o_data, 32'hFFFFFFF4);
        step32(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        step32(1, 0, 0, 1, 2'd2, 0, 2'd1, 32'hAABBCCDD, 2'b00, 6'd9);
        chk("r44_data", f32.o_data, 32'hDDAABBCC);
        chk("r44_mis", f32.o_misaligned, 1'b1);
        step32(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Fill to full, refused fifth push, push+pop while full
        for (int i = 0; i < 5; i++) step32(1, 0, 0, 1, 2'd2, 0, 2'd0, 32'h1000 + i, 2'b00, 6'(i));
        chk("r46_rdy", f32.o_ready, 1'b0);
        chk("r46_cnt4", f32.o_count, 3'd4);
        step32(1, 1, 0, 1, 2'd2, 0, 2'd0, 32'h2222, 2'b00, 6'd1);
        chk("r46_cnt3", f32.o_count, 3'd3);
        chk("r46_head", f32.o_data, 32'h1001);
        repeat (3) step32(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Flush discards the concurrent push
        repeat (2) step32(1, 0, 0, 0, 0, 0, 0, 32'h55, 2'b00, 6'd2);
        step32(1, 0, 1, 0, 0, 0, 0, 32'h66, 2'b00, 6'd3);
        chk("r47_cnt", f32.o_count, 3'd0);
        chk("r47_v", f32.o_valid, 1'b0);

        step32(1, 0, 0, 1, 2'd2, 0, 2'd0, 32'hFFFFFFFF, 2'b01, 6'd4);
        chk("r48_data", f32.o_data, 32'h0);
        chk("r48_flt", f32.o_fault, 2'b01);
        step32(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            step32($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0,
                   $urandom_range(0, 3) != 0, 2'($urandom), 1'($urandom), 2'($urandom), $urandom,
                   ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, 6'($urandom_range(0, 45)));
        end

        // Async reset mid-stream, with a push pending in the same cycle
        step32(1, 0, 0, 1, 2'd0, 0, 2'd3, 32'hA5000000, 2'b00, 6'd11);
        step32(1, 0, 0, 1, 2'd1, 1, 2'd2, 32'h80000000, 2'b00, 6'd12);
        f32.i_valid = 1'b1;
        #2 rst = 1'b1;
        #1 check_reset_outputs("rstmid");
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_hold_cnt", f32.o_count, 3'd0);
        rst = 1'b0;
        q32.delete();
        f32.i_valid = 1'b0;
        step32(1, 0, 0, 1, 2'd1, 1, 2'd2, 32'h80010000, 2'b00, 6'd13);
        chk("post_rst_data", f32.o_data, 32'hFFFF8001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=%0d exp=%0d", 0, 1);
        $fatal(1, "bench timed out");
    end
endmodule
